branch_unit: RTL and testbench
==============================

# branch_unit

- Resolves every control-flow decision for the single-cycle LEGv8 datapath.
- Sits directly upstream of the fetch stage and drives its `pc_src` and `branch_target` inputs.
- Owns the architectural NZCV flag register, updates it from flag-setting ALU instructions, and evaluates B, BL, BR, CBZ, CBNZ and B.cond.
- Also produces the link write for BL.

## Interface
Parameters:
- `WIDTH`, default `` `WORD `` (64): datapath width.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `instruction`  input  32  current instruction from fetch.
- `pc`  input  WIDTH  address of the current instruction.
- `reg_data`  input  WIDTH  register-file read data: Rt for CB-format, Rn for BR.
- `alu_flags`  input  4  {N,Z,C,V} produced by the ALU this cycle.
- `pc_src`  output  2  next-PC select: 0 = pc+4, 1 = `branch_target`, 2 = register (BR).
- `branch_target`  output  WIDTH  pc + sign-extended offset × 4.
- `link_write`  output  1  write X30 this cycle (BL).
- `link_data`  output  WIDTH  pc + 4.
- `flags`  output  4  current registered NZCV, for debug and trace.

## Operation
Opcode decode uses `instruction[31:21]` prefixes:
- B: `000101`.
- BL: `100101`.
- CBZ: `10110100`.
- CBNZ: `10110101`.
- B.cond: `01010100`.
- BR: `11010110000`.
- Flag-setters: ADDS `10101011000`, SUBS `11101011000`, ANDS `11101010000`, ADDIS `1011000101`, SUBIS `1111000101`, ANDIS `1111001001`.

Offset extraction:
- B/BL: `imm26 = instruction[25:0]`.
- CB/B.cond: `imm19 = instruction[23:5]`.
- Sign-extend to WIDTH, shift left 2, add to `pc`.
- Addition wraps modulo 2^WIDTH.
- `branch_target` is always driven, even when `pc_src` ≠ 1.

`pc_src` selection:
- 1 for B, BL, CBZ when `reg_data == 0`, CBNZ when `reg_data != 0`, and B.cond when the condition holds.
- 2 for BR.
- 0 otherwise, including for any undecodable instruction.

B.cond condition code is `instruction[4:0]`:
- 0 EQ Z
- 1 NE !Z
- 2 HS C
- 3 LO !C
- 4 MI N
- 5 PL !N
- 6 VS V
- 7 VC !V
- 8 HI C&!Z
- 9 LS !(C&!Z)
- 10 GE N==V
- 11 LT N!=V
- 12 GT !Z&(N==V)
- 13 LE !(!Z&(N==V))
- 14–15 always.
- Codes 16–31 are never taken.

Flags and link:
- The flag register loads `alu_flags` on the rising edge when the current instruction is a flag-setter; otherwise it holds.
- `link_write` = 1 only for BL.

## Timing
- `pc_src`, `branch_target`, `link_write` and `link_data` are combinational from `instruction`, `pc`, `reg_data` and the registered flags. They resolve within the same cycle the instruction is presented.
- Flag update latency is one cycle: a B.cond sees flags from the most recent preceding flag-setter, never from itself. This matches ARM semantics, because a single-cycle datapath cannot carry a flag-setter and a B.cond in the same cycle.
- While `reset` is low:
  - `flags` = 4'b0000 immediately (asynchronous).
  - `pc_src` = 0.
  - `link_write` = 0.
  - `branch_target` and `link_data` still follow their inputs.
- Reset asserted mid-cycle clears flags at once; a flag update pending on that edge is lost.
- Release: the first rising edge after `reset` goes high is the first edge that may load flags.

## Structure
- Opcode prefixes, the `pc_src` encodings (`PC_INC`, `PC_BRANCH`, `PC_REG`) and condition-code values go in the shared `constants.vh` alongside `` `WORD `` and `` `INSTR_LEN ``.
- Fetch uses the same `pc_src` encodings.
- One combinational sub-module, `cond_eval` (inputs: 4-bit cond, NZCV; output: taken), keeps the condition table separately testable.
- The flag register is local to this block.

## Test plan
- Reset low with SUBS and `alu_flags` = 4'b1111 presented: `flags` stays 0000. After release and one edge, `flags` = 1111.
- B at pc=0x100 with `imm26` = −4 (0x3FFFFFC): `pc_src` = 1, `branch_target` = 0xF0. BL with `imm26` = 1 at pc=0x100: target 0x104, `link_write` = 1, `link_data` = 0x104.
- CBZ at pc=0x200 with `imm19` = 3:
  - `reg_data` = 0 → `pc_src` = 1, target 0x20C.
  - `reg_data` = 5 → `pc_src` = 0.
  - CBNZ with the same values gives the inverse results.
- SUBS with `alu_flags` = 0100 (Z), then B.EQ → taken. Then ADD (non-setter) with `alu_flags` = 0000, then B.NE → not taken, because flags held.
- Sweep `cond_eval` over all 16 NZCV combinations × codes 0–15: each result matches the table. Code 14 is always taken.
- BR with `reg_data` = 0x4000 → `pc_src` = 2. An undefined opcode (0x00000000) gives `pc_src` = 0 and `link_write` = 0.

Source files
------------

// File: rtl/branch_unit_pkg.sv
// Shared LEGv8 control-flow constants: opcode prefixes, next-PC select encodings and
// condition codes, plus the branch-class decoder used by the branch unit.
package branch_unit_pkg;

    localparam int unsigned WORD      = 64;
    localparam int unsigned INSTR_LEN = 32;

    // Next-PC select, shared with fetch
    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_REG    = 2'd2;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_ANDS  = 11'b11101010000;
    localparam logic [9:0]  OP_ADDIS = 10'b1011000101;
    localparam logic [9:0]  OP_SUBIS = 10'b1111000101;
    localparam logic [9:0]  OP_ANDIS = 10'b1111001001;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_HS = 4'd2;
    localparam logic [3:0] COND_LO = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    typedef enum logic [2:0] {
        BrNone, BrB, BrBl, BrCbz, BrCbnz, BrCond, BrReg
    } br_kind_e;

    function automatic br_kind_e decode_branch(input logic [INSTR_LEN-1:0] instr);
        br_kind_e kind;
        kind = BrNone;
        if (instr[31:26] == OP_B)          kind = BrB;
        else if (instr[31:26] == OP_BL)    kind = BrBl;
        else if (instr[31:24] == OP_CBZ)   kind = BrCbz;
        else if (instr[31:24] == OP_CBNZ)  kind = BrCbnz;
        else if (instr[31:24] == OP_BCOND) kind = BrCond;
        else if (instr[31:21] == OP_BR)    kind = BrReg;
        return kind;
    endfunction

    function automatic logic is_flag_setter(input logic [INSTR_LEN-1:0] instr);
        return (instr[31:21] == OP_ADDS) || (instr[31:21] == OP_SUBS) ||
               (instr[31:21] == OP_ANDS) || (instr[31:22] == OP_ADDIS) ||
               (instr[31:22] == OP_SUBIS) || (instr[31:22] == OP_ANDIS);
    endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Datapath-facing bundle of the branch unit: instruction/operands in, next-PC control out.
interface branch_unit_if
    import branch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WORD
) ();
    logic [INSTR_LEN-1:0] instruction;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     reg_data;
    logic [3:0]           alu_flags;
    logic [1:0]           pc_src;
    logic [WIDTH-1:0]     branch_target;
    logic                 link_write;
    logic [WIDTH-1:0]     link_data;
    logic [3:0]           flags;

    modport master (
        output instruction, pc, reg_data, alu_flags,
        input  pc_src, branch_target, link_write, link_data, flags
    );

    modport slave (
        input  instruction, pc, reg_data, alu_flags,
        output pc_src, branch_target, link_write, link_data, flags
    );
endinterface

// File: rtl/branch_unit_cond_eval.sv
// B.cond condition evaluator: maps a 4-bit condition code and NZCV to taken.
module branch_unit_cond_eval
    import branch_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);
    logic n, z, c, v;

    always_comb begin
        {n, z, c, v} = nzcv;
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c && !z;
            COND_LS: taken = !(c && !z);
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = !(!z && (n == v));
            default: taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_unit.sv
// Control-flow resolution for the single-cycle LEGv8 datapath: next-PC select, branch
// target, BL link write, and the architectural NZCV register.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WORD
) (
    input logic          clk,
    input logic          reset,
    branch_unit_if.slave bus
);
    logic [3:0]       flags_q;
    br_kind_e         kind;
    logic             cond_true;
    logic [WIDTH-1:0] offset;

    assign kind = decode_branch(bus.instruction);

    branch_unit_cond_eval u_cond_eval (
        .cond  (bus.instruction[3:0]),
        .nzcv  (flags_q),
        .taken (cond_true)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (is_flag_setter(bus.instruction)) begin
            flags_q <= bus.alu_flags;
        end
    end

    always_comb begin
        if (kind == BrB || kind == BrBl) begin
            offset = {{(WIDTH-26){bus.instruction[25]}}, bus.instruction[25:0]};
        end else begin
            offset = {{(WIDTH-19){bus.instruction[23]}}, bus.instruction[23:5]};
        end
    end

    assign bus.branch_target = bus.pc + (offset << 2);
    assign bus.link_data     = bus.pc + WIDTH'(4);
    assign bus.flags         = flags_q;

    // Control outputs are forced idle while reset is held; targets keep tracking inputs.
    always_comb begin
        bus.pc_src     = PC_INC;
        bus.link_write = 1'b0;
        if (reset) begin
            unique case (kind)
                BrB:     bus.pc_src = PC_BRANCH;
                BrBl: begin
                    bus.pc_src     = PC_BRANCH;
                    bus.link_write = 1'b1;
                end
                BrCbz:   bus.pc_src = (bus.reg_data == '0) ? PC_BRANCH : PC_INC;
                BrCbnz:  bus.pc_src = (bus.reg_data != '0) ? PC_BRANCH : PC_INC;
                // Codes 16-31 never branch
                BrCond:  bus.pc_src = (!bus.instruction[4] && cond_true) ? PC_BRANCH : PC_INC;
                BrReg:   bus.pc_src = PC_REG;
                BrNone:  bus.pc_src = PC_INC;
                default: bus.pc_src = PC_INC;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: vector table through a scoreboard, a full
// condition-code sweep, and reset corner sequences.
module tb_branch_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    branch_unit_if #(.WIDTH(64)) bus ();

    branch_unit #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] rd;
        logic [3:0]  alu;
        logic [1:0]  pc_src;
        logic [63:0] tgt;
        logic        chk_tgt;
        logic        lw;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs[22];
    vec_t sb[$];
    logic [3:0] model_flags;

    function automatic vec_t mkv(logic [31:0] instr, logic [63:0] pc, logic [63:0] rd,
                                 logic [3:0] alu, logic [1:0] pc_src, logic [63:0] tgt,
                                 logic chk_tgt, logic lw, logic [3:0] flg);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rd = rd; v.alu = alu; v.pc_src = pc_src;
        v.tgt = tgt; v.chk_tgt = chk_tgt; v.lw = lw; v.flg = flg;
        return v;
    endfunction

    function automatic logic ref_cond(int code, logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (code)
            0: return z;
            1: return !z;
            2: return c;
            3: return !c;
            4: return n;
            5: return !n;
            6: return v;
            7: return !v;
            8: return c & ~z;
            9: return ~c | z;
            10: return n ~^ v;
            11: return n ^ v;
            12: return ~z & (n ~^ v);
            13: return z | (n ^ v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.instruction = v.instr;
        bus.pc          = v.pc;
        bus.reg_data    = v.rd;
        bus.alu_flags   = v.alu;
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        cmp({tag, " pc_src"}, 64'(bus.pc_src), 64'(e.pc_src));
        cmp({tag, " link_write"}, 64'(bus.link_write), 64'(e.lw));
        cmp({tag, " link_data"}, bus.link_data, e.pc + 64'd4);
        cmp({tag, " flags"}, 64'(bus.flags), 64'(e.flg));
        if (e.chk_tgt) cmp({tag, " target"}, bus.branch_target, e.tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mkv(32'h17FFFFFC, 64'h100, 0, 4'h0, 2'd1, 64'hF0,  1, 0, 4'b1111);
        vecs[1]  = mkv(32'h94000001, 64'h100, 0, 4'h0, 2'd1, 64'h104, 1, 1, 4'b1111);
        vecs[2]  = mkv(32'hB4000060, 64'h200, 0, 4'h0, 2'd1, 64'h20C, 1, 0, 4'b1111);
        vecs[3]  = mkv(32'hB4000060, 64'h200, 5, 4'h0, 2'd0, 64'h20C, 1, 0, 4'b1111);
        vecs[4]  = mkv(32'hB5000060, 64'h200, 0, 4'h0, 2'd0, 64'h20C, 1, 0, 4'b1111);
        vecs[5]  = mkv(32'hB5000060, 64'h200, 5, 4'h0, 2'd1, 64'h20C, 1, 0, 4'b1111);
        vecs[6]  = mkv(32'hEB000000, 64'h300, 0, 4'b0100, 2'd0, 64'h300, 1, 0, 4'b1111);
        vecs[7]  = mkv(32'h54000040, 64'h300, 0, 4'h0, 2'd1, 64'h308, 1, 0, 4'b0100);
        vecs[8]  = mkv(32'h8B000000, 64'h300, 0, 4'h0, 2'd0, 64'h300, 1, 0, 4'b0100);
        vecs[9]  = mkv(32'h54000041, 64'h300, 0, 4'h0, 2'd0, 64'h308, 1, 0, 4'b0100);
        vecs[10] = mkv(32'h54000050, 64'h300, 0, 4'h0, 2'd0, 64'h308, 1, 0, 4'b0100);
        vecs[11] = mkv(32'hAB000000, 64'h300, 0, 4'b1001, 2'd0, 64'h300, 1, 0, 4'b0100);
        vecs[12] = mkv(32'h5400004A, 64'h300, 0, 4'h0, 2'd1, 64'h308, 1, 0, 4'b1001);
        vecs[13] = mkv(32'h5400004B, 64'h300, 0, 4'h0, 2'd0, 64'h308, 1, 0, 4'b1001);
        vecs[14] = mkv(32'hD61F03C0, 64'h400, 64'h4000, 4'h0, 2'd2, 0, 0, 0, 4'b1001);
        vecs[15] = mkv(32'h00000000, 64'h500, 0, 4'h0, 2'd0, 64'h500, 1, 0, 4'b1001);
        vecs[16] = mkv(32'hEA000000, 64'h300, 0, 4'b0010, 2'd0, 0, 0, 0, 4'b1001);
        vecs[17] = mkv(32'hB1400000, 64'h300, 0, 4'b0000, 2'd0, 0, 0, 0, 4'b0010);
        vecs[18] = mkv(32'hF1400000, 64'h300, 0, 4'b1000, 2'd0, 0, 0, 0, 4'b0000);
        vecs[19] = mkv(32'hF2400000, 64'h300, 0, 4'b0001, 2'd0, 0, 0, 0, 4'b1000);
        vecs[20] = mkv(32'h54000046, 64'h300, 0, 4'h0, 2'd1, 64'h308, 1, 0, 4'b0001);
        vecs[21] = mkv(32'h54000044, 64'h300, 0, 4'h0, 2'd0, 64'h308, 1, 0, 4'b0001);

        // Reset held: control outputs idle, targets still follow inputs
        drive(mkv(32'h94000001, 64'h100, 0, 4'hF, 0, 0, 0, 0, 0));
        @(negedge clk);
        cmp("rst pc_src", 64'(bus.pc_src), 0);
        cmp("rst link_write", 64'(bus.link_write), 0);
        cmp("rst target", bus.branch_target, 64'h104);
        cmp("rst link_data", bus.link_data, 64'h104);
        drive(mkv(32'hEB000000, 64'h100, 0, 4'hF, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        #1;
        cmp("rst flags held", 64'(bus.flags), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        cmp("release flags", 64'(bus.flags), 0);
        @(posedge clk);
        #1;
        cmp("first edge flags", 64'(bus.flags), 64'hF);

        for (int i = 0; i < 22; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Condition sweep through the flag register; alu_flags on the B.cond itself is
        // the complement, so a same-cycle flag path would be caught
        model_flags = 4'b0001;
        for (int n = 0; n < 16; n++) begin
            apply(mkv(32'hEB000000, 64'h300, 0, 4'(n), 2'd0, 64'h300, 1, 0, model_flags),
                  $sformatf("sweep subs%0d", n));
            model_flags = 4'(n);
            for (int c = 0; c < 16; c++) begin
                apply(mkv(32'h54000040 | 32'(c), 64'h300, 0, ~model_flags,
                          ref_cond(c, model_flags) ? 2'd1 : 2'd0, 64'h308, 1, 0, model_flags),
                      $sformatf("sweep nzcv%0d cond%0d", n, c));
            end
        end

        // Mid-cycle reset clears flags at once and drops the pending update
        @(posedge clk);
        #1;
        drive(mkv(32'hEB000000, 64'h300, 0, 4'b0110, 0, 0, 0, 0, 0));
        #2;
        reset = 1'b0;
        #1;
        cmp("midrst flags", 64'(bus.flags), 0);
        drive(mkv(32'h17FFFFFC, 64'h100, 0, 4'b0110, 0, 0, 0, 0, 0));
        #1;
        cmp("midrst pc_src", 64'(bus.pc_src), 0);
        cmp("midrst target", bus.branch_target, 64'hF0);
        drive(mkv(32'hEB000000, 64'h300, 0, 4'b0110, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        cmp("midrst edge flags", 64'(bus.flags), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cmp("post release flags", 64'(bus.flags), 64'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
